// File: rtl/seq_pkg.sv
// Shared types and constants for the core run sequencer: state encoding,
// halt opcode and instruction-type field decode.
package seq_pkg;

    localparam int INSTR_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } seq_state_e;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h000;

    // Instruction-type field, top two bits of mach_code
    localparam logic [1:0] OPC_R = 2'b00;
    localparam logic [1:0] OPC_M = 2'b01;
    localparam logic [1:0] OPC_B = 2'b10;
    localparam logic [1:0] OPC_S = 2'b11;

    function automatic logic [1:0] opc_type(input logic [INSTR_W-1:0] code);
        return code[INSTR_W-1:INSTR_W-2];
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Datapath control bundle between the run sequencer (master) and the
// fetch/decode/execute datapath (slave).
interface core_sequencer_if;
    import seq_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               ctl_reg_write;
    logic               ctl_mem_read;
    logic               ctl_mem_write;
    logic               ctl_jump;

    logic               pc_clear;
    logic               pc_inc;
    logic               pc_jump;
    logic               ir_load;
    logic               reg_wen;
    logic               mem_ren;
    logic               mem_wen;

    modport master (
        input  instr, ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_jump,
        output pc_clear, pc_inc, pc_jump, ir_load, reg_wen, mem_ren, mem_wen
    );

    modport slave (
        output instr, ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_jump,
        input  pc_clear, pc_inc, pc_jump, ir_load, reg_wen, mem_ren, mem_wen
    );

endinterface

// File: rtl/seq_watchdog.sv
// Busy-cycle limit comparator and sticky timeout flag; the flag clears when a
// new run enters CLEAR.
module seq_watchdog #(
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             check_en,
    input  logic [CNT_W-1:0] cycle_count,
    output logic             expire,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WDOG_LIMIT - 1);

    logic timeout_d, timeout_q;

    assign expire  = check_en && (cycle_count == LIMIT_M1);
    assign timeout = timeout_q;

    always_comb begin
        timeout_d = timeout_q;
        if (clear) begin
            timeout_d = 1'b0;
        end else if (expire) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle run controller for the 9-bit accumulator core: sequences
// FETCH/DECODE/EXEC/WB, counts cycles and retired instructions.
// Optional watchdog forced halt when SEQ_WATCHDOG_EN is defined.
module core_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    core_sequencer_if.master dp,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_e       state_d, state_q;
    logic [CNT_W-1:0] cyc_d, cyc_q;
    logic [CNT_W-1:0] ins_d, ins_q;
    logic             retire;
    logic             wdog_expire;

    assign cycle_count = cyc_q;
    assign instr_count = ins_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start only matters in IDLE and HALT; busy states run to completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = (dp.instr == HALT_INSTR) ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_d = dp.ctl_mem_read ? ST_WB : ST_FETCH;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   if (!start) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (wdog_expire) state_d = ST_HALT;
    end

    always_comb begin
        dp.pc_clear = 1'b0;
        dp.pc_inc   = 1'b0;
        dp.pc_jump  = 1'b0;
        dp.ir_load  = 1'b0;
        dp.reg_wen  = 1'b0;
        dp.mem_ren  = 1'b0;
        dp.mem_wen  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        retire      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy        = 1'b1;
                dp.pc_clear = 1'b1;
            end
            ST_FETCH: begin
                busy       = 1'b1;
                dp.ir_load = 1'b1;
            end
            ST_DECODE: busy = 1'b1;
            ST_EXEC: begin
                busy       = 1'b1;
                dp.mem_wen = dp.ctl_mem_write;
                dp.mem_ren = dp.ctl_mem_read;
                // Loads defer the register write and PC step to WB
                if (!dp.ctl_mem_read) begin
                    dp.reg_wen = dp.ctl_reg_write;
                    dp.pc_jump = dp.ctl_jump;
                    dp.pc_inc  = !dp.ctl_jump;
                    retire     = 1'b1;
                end
            end
            ST_WB: begin
                busy       = 1'b1;
                dp.reg_wen = 1'b1;
                dp.pc_inc  = 1'b1;
                retire     = 1'b1;
            end
            ST_HALT: done = 1'b1;
            default: ;
        endcase
    end

    // CLEAR restarts both counters; the CLEAR cycle itself counts as busy
    always_comb begin
        cyc_d = cyc_q;
        ins_d = ins_q;
        if (state_q == ST_CLEAR) begin
            cyc_d = CNT_W'(1);
            ins_d = '0;
        end else begin
            if (busy && (cyc_q != '1)) cyc_d = cyc_q + CNT_W'(1);
            if (retire && (ins_q != '1)) ins_d = ins_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    seq_watchdog #(
        .CNT_W      (CNT_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .clear       (state_q == ST_CLEAR),
        .check_en    (busy && (state_q != ST_CLEAR)),
        .cycle_count (cyc_q),
        .expire      (wdog_expire),
        .timeout     (timeout)
    );
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_expire       = 1'b0;
    assign timeout           = 1'b0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a behavioural datapath (PC, program memory,
// decode) plus a per-instruction cycle-table reference model.
module tb_core_sequencer;
    import seq_pkg::*;

    localparam int CNT_W = 16;
`ifdef SEQ_WATCHDOG_EN
    localparam int WD_LIMIT = 16;
`else
    localparam int WD_LIMIT = 0;
`endif

    // Expected strobe vectors {pc_clear,pc_inc,pc_jump,ir_load,reg_wen,mem_ren,mem_wen,busy}
    localparam logic [7:0] V_CLEAR = 8'b1000_0001;
    localparam logic [7:0] V_FETCH = 8'b0001_0001;
    localparam logic [7:0] V_DEC   = 8'b0000_0001;
    localparam logic [7:0] V_ALU_W = 8'b0100_1001;
    localparam logic [7:0] V_INC   = 8'b0100_0001;
    localparam logic [7:0] V_LOAD  = 8'b0000_0101;
    localparam logic [7:0] V_STORE = 8'b0100_0011;
    localparam logic [7:0] V_JUMP  = 8'b0010_0001;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, done, timeout;
    logic [CNT_W-1:0] cycle_count, instr_count;

    always #5 clk = ~clk;

    core_sequencer_if dp_if ();

    core_sequencer #(
        .CNT_W      (CNT_W),
        .WDOG_LIMIT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dp          (dp_if),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    // Behavioural datapath: program memory, PC and instruction decode
    logic [8:0] prog [64];
    logic [5:0] env_pc;

    assign dp_if.instr         = prog[env_pc];
    assign dp_if.ctl_reg_write = (opc_type(dp_if.instr) == OPC_R) ||
                                 ((opc_type(dp_if.instr) == OPC_S) && dp_if.instr[5]);
    assign dp_if.ctl_mem_read  = (opc_type(dp_if.instr) == OPC_M) && dp_if.instr[6];
    assign dp_if.ctl_mem_write = (opc_type(dp_if.instr) == OPC_M) && !dp_if.instr[6];
    assign dp_if.ctl_jump      = (opc_type(dp_if.instr) == OPC_B) && dp_if.instr[6];

    always @(posedge clk or posedge reset) begin
        if (reset)                env_pc <= '0;
        else if (dp_if.pc_clear)  env_pc <= '0;
        else if (dp_if.pc_inc)    env_pc <= env_pc + 6'd1;
        else if (dp_if.pc_jump)   env_pc <= env_pc + 6'(dp_if.instr[2:0]);
    end

    logic [7:0] obs_vec;
    assign obs_vec = {dp_if.pc_clear, dp_if.pc_inc, dp_if.pc_jump, dp_if.ir_load,
                      dp_if.reg_wen, dp_if.mem_ren, dp_if.mem_wen, busy};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-instruction cycle tables walked over the program
    logic [7:0] exp_q [$];
    bit         ret_q [$];
    int         exp_instr;
    bit         exp_to;

    task automatic build_model();
        logic [5:0] pc;
        logic [8:0] ins;
        exp_q.delete();
        ret_q.delete();
        exp_q.push_back(V_CLEAR); ret_q.push_back(1'b0);
        pc = '0;
        for (int it = 0; it < 64; it++) begin
            ins = prog[pc];
            exp_q.push_back(V_FETCH); ret_q.push_back(1'b0);
            exp_q.push_back(V_DEC);   ret_q.push_back(1'b0);
            if (ins == HALT_INSTR) break;
            case (ins[8:7])
                OPC_R: begin
                    exp_q.push_back(V_ALU_W); ret_q.push_back(1'b1); pc = pc + 6'd1;
                end
                OPC_M: begin
                    if (ins[6]) begin
                        exp_q.push_back(V_LOAD);  ret_q.push_back(1'b0);
                        exp_q.push_back(V_ALU_W); ret_q.push_back(1'b1);
                    end else begin
                        exp_q.push_back(V_STORE); ret_q.push_back(1'b1);
                    end
                    pc = pc + 6'd1;
                end
                OPC_B: begin
                    if (ins[6]) begin
                        exp_q.push_back(V_JUMP); ret_q.push_back(1'b1); pc = pc + 6'(ins[2:0]);
                    end else begin
                        exp_q.push_back(V_INC);  ret_q.push_back(1'b1); pc = pc + 6'd1;
                    end
                end
                default: begin
                    exp_q.push_back(ins[5] ? V_ALU_W : V_INC); ret_q.push_back(1'b1);
                    pc = pc + 6'd1;
                end
            endcase
        end
        exp_to = 1'b0;
        if (WD_LIMIT > 0 && exp_q.size() >= WD_LIMIT) begin
            while (exp_q.size() > WD_LIMIT) begin
                void'(exp_q.pop_back());
                void'(ret_q.pop_back());
            end
            exp_to = 1'b1;
        end
        exp_instr = 0;
        foreach (ret_q[i]) exp_instr += int'(ret_q[i]);
    endtask

    function automatic logic [8:0] rand_instr();
        logic [8:0] r;
        case ($urandom_range(0, 4))
            0:       r = {OPC_R, 7'($urandom) | 7'h01};
            1:       r = {OPC_M, 1'b1, 6'($urandom)};
            2:       r = {OPC_M, 1'b0, 6'($urandom)};
            3:       r = {OPC_B, 1'($urandom), 3'b000, 3'($urandom_range(1, 4))};
            default: r = {OPC_S, 7'($urandom)};
        endcase
        return r;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = HALT_INSTR;
    endtask

    // One complete run from IDLE, checked cycle by cycle against the model
    task automatic run_program(input string tag, input bit drop_early);
        int n;
        build_model();
        @(negedge clk);
        check({tag, "_idle"}, {done, obs_vec}, 9'h000);
        start = 1'b1;
        n = 0;
        foreach (exp_q[i]) begin
            @(negedge clk);
            check($sformatf("%s_cyc%0d", tag, i), obs_vec, exp_q[i]);
            n++;
            if (drop_early && n == 3) start = 1'b0;
        end
        @(negedge clk);
        check({tag, "_halt"}, {timeout, done, obs_vec}, {exp_to, 1'b1, 8'h00});
        check({tag, "_cycles"}, cycle_count, exp_q.size());
        check({tag, "_instrs"}, instr_count, exp_instr);
        if (!drop_early) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check({tag, "_hold"}, {done, obs_vec}, 9'h100);
            end
            start = 1'b0;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        check({tag, "_back_idle"}, {done, obs_vec}, 9'h000);
        check({tag, "_cnt_hold"}, {cycle_count, instr_count}, {16'(exp_q.size()), 16'(exp_instr)});
    endtask

    initial begin
        #500000;
        $display("FAIL tb_time_limit: observed no end, expected $finish");
        $fatal(1, "time limit");
    end

    initial begin
        int nbusy;
        bit seen;
        reset = 1'b1;
        start = 1'b0;
        clear_prog();
        repeat (3) @(negedge clk);
        check("reset_outs", {timeout, done, obs_vec}, 10'h000);
        check("reset_cnts", {cycle_count, instr_count}, 32'h0);
        reset = 1'b0;

        // ADD, ADD, halt
        clear_prog();
        prog[0] = {OPC_R, 7'h03};
        prog[1] = {OPC_R, 7'h05};
        run_program("add2", 1'b0);
        check("add2_cycles_const", cycle_count, 9);
        check("add2_instrs_const", instr_count, 2);

        // LB, halt
        clear_prog();
        prog[0] = {OPC_M, 1'b1, 6'h02};
        run_program("load", 1'b0);
        check("load_instrs_const", instr_count, 1);

        // Taken branch over one slot, then not-taken branch, halt
        clear_prog();
        prog[0] = {OPC_B, 1'b1, 3'b000, 3'd2};
        prog[1] = {OPC_R, 7'h11};
        prog[2] = {OPC_B, 1'b0, 3'b000, 3'd3};
        prog[3] = {OPC_S, 7'h20};
        run_program("branch", 1'b0);

        // Randomised programs; one drops start mid-run
        for (int r = 0; r < 6; r++) begin
            int len;
            clear_prog();
            len = $urandom_range(3, 12);
            for (int i = 0; i < len; i++) prog[i] = rand_instr();
            run_program($sformatf("rand%0d", r), r == 2);
        end

        // Reset during the EXEC of a store
        clear_prog();
        prog[0] = {OPC_R, 7'h01};
        prog[1] = {OPC_M, 1'b0, 6'h07};
        prog[2] = {OPC_R, 7'h01};
        @(negedge clk);
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dp_if.mem_wen) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_store_seen", seen, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid_outs", {timeout, done, obs_vec}, 10'h000);
        check("rst_mid_cnts", {cycle_count, instr_count}, 32'h0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_after_idle", {done, obs_vec}, 9'h000);

        // Infinite loop: branch to itself
        clear_prog();
        prog[0] = {OPC_B, 1'b1, 3'b000, 3'd0};
        @(negedge clk);
        start = 1'b1;
        nbusy = 0;
`ifdef SEQ_WATCHDOG_EN
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) break;
        end
        check("wdog_busy_cycles", nbusy, 16);
        check("wdog_halt", {timeout, done, busy}, 3'b110);
        check("wdog_cycle_count", cycle_count, 16);
        start = 1'b0;
        @(negedge clk);
        check("wdog_idle", {done, obs_vec}, 9'h000);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        check("loop_busy_cycles", nbusy, 40);
        check("loop_still_running", {timeout, done, busy}, 3'b001);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
`endif

        // Fresh run afterwards: counters and timeout restart
        clear_prog();
        prog[0] = {OPC_R, 7'h03};
        prog[1] = {OPC_M, 1'b0, 6'h01};
        run_program("rerun", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle run controller for the 9-bit accumulator-style core. It sits between the top-level start/done handshake and the fetch/decode/execute datapath (program counter, instruction memory, control unit, register file, data memory), sequencing each instruction through fetch, decode, execute and optional write-back states. It detects the halt instruction, drives every datapath enable, counts cycles and retired instructions, and optionally enforces a watchdog timeout.

## Interface
- CNT_W, 16, width of cycle and instruction counters
- WDOG_LIMIT, 4096, busy-cycle limit before forced halt; only used with watchdog compiled in
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  level run request from testbench/top level
- instr  in  9  current mach_code from instruction memory
- ctl_reg_write  in  1  decoded register-file write request
- ctl_mem_read  in  1  decoded load
- ctl_mem_write  in  1  decoded store
- ctl_jump  in  1  decoded branch/jump taken (flags already resolved)
- pc_clear  out  1  synchronous PC clear to 0
- pc_inc  out  1  PC += 1
- pc_jump  out  1  PC += jumpAmount
- ir_load  out  1  latch instr into instruction register
- reg_wen  out  1  register-file write enable
- mem_ren  out  1  data-memory read strobe
- mem_wen  out  1  data-memory write enable
- busy  out  1  program running
- done  out  1  program finished
- timeout  out  1  finish was forced by watchdog
- cycle_count  out  CNT_W  busy cycles of last/current run
- instr_count  out  CNT_W  retired instructions of last/current run

## Operation
- States: IDLE, CLEAR, FETCH, DECODE, EXEC, WB, HALT (enum in package).
- IDLE: all strobes 0, busy=0. start=1 -> CLEAR.
- CLEAR: pc_clear=1; counters and timeout cleared -> FETCH.
- FETCH: ir_load=1 -> DECODE.
- DECODE: instr==9'h000 -> HALT (halt not counted as retired); else -> EXEC.
- EXEC: mem_wen=ctl_mem_write, mem_ren=ctl_mem_read. Load: -> WB, no PC update. Otherwise: reg_wen=ctl_reg_write; pc_jump=ctl_jump, pc_inc=!ctl_jump; instr_count++; -> FETCH.
- WB: reg_wen=1, pc_inc=1, instr_count++ -> FETCH.
- pc_inc and pc_jump are never both 1; pc_clear is exclusive of both.
- HALT: done=1, busy=0; stays until start=0 -> IDLE (done drops). Holding start high never retriggers a run.
- start is ignored in all busy states (CLEAR..WB); deasserting it mid-run does not abort.
- cycle_count increments every cycle in CLEAR..WB, saturates at all-ones; instr_count saturates likewise. Both hold in HALT/IDLE for readback.
- Reset mid-run: immediate return to IDLE, all outputs 0, counters 0; no partial write-back.

## Timing
- All outputs registered or decoded from registered state only (no combinational start->strobe path).
- Reset values: every output 0, state IDLE.
- start=1 sampled in IDLE -> pc_clear at cycle +1, first ir_load at +2.
- Non-load instruction: 3 cycles (FETCH, DECODE, EXEC). Load: 4 cycles; data memory read data valid in WB.
- Halt instruction fetched -> done=1 two cycles after its FETCH cycle.
- done->IDLE: one cycle after start sampled 0.

## Configuration
- SEQ_WATCHDOG_EN defined: when cycle_count reaches WDOG_LIMIT-1 in any busy state, next state is HALT with timeout=1 (overrides all other transitions; strobes of that cycle still issued). timeout clears in CLEAR.
- Undefined: no watchdog logic; timeout tied 0; run ends only on halt instruction or reset.

## Structure
- Package seq_pkg: state enum, HALT_INSTR=9'h000, opcode-type constants (R=2'b00, M=2'b01, B=2'b10, S=2'b11).
- One sub-module, seq_watchdog (limit comparator + timeout flag), instantiated only under SEQ_WATCHDOG_EN.

## Test plan
- Reset then start=1 with program ADD, ADD, halt -> pc_clear one cycle, 2 retired, instr_count=2, cycle_count=1+3+3+2=9, done=1, timeout=0.
- Load (LB) followed by halt -> WB state seen, mem_ren in EXEC, reg_wen+pc_inc in WB, instr_count=1.
- Taken branch (ctl_jump=1) -> pc_jump=1, pc_inc=0 in EXEC; not-taken -> pc_inc=1 only.
- done held while start=1 for 10 cycles, no rerun; start=0 -> IDLE next cycle; new start repeats run with counters reset.
- Assert reset during EXEC of a store -> all strobes 0 immediately, state IDLE, counters 0.
- SEQ_WATCHDOG_EN, WDOG_LIMIT=16, infinite-loop program -> HALT after 16 busy cycles, timeout=1, done=1; without macro, run continues past 16 cycles.
